ptp_host: RTL

- Host-side initiator for the parallel transfer protocol (PTP) that feeds the baby's 32-bit RAM input and drains its address/data outputs over 8-bit byte lanes.
- Serialises a 32-bit word into 4 strobed bytes toward the chip's input assembler, toggling ctrl_a. Reads the chip's 8-byte (address word, then data word) output stream by toggling ctrl_b.
- Drives the PTP reset line.
- Used in the FPGA RAM emulator and as the bench driver for the top level.

---
 rtl/ptp_host.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/ptp_host.sv
// Host-side PTP initiator. It serialises 32-bit words onto the chip's byte lane
// under ctrl_a, and reads back the 8-byte address/data stream under ctrl_b.
module ptp_host #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned HOLD_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned RST_CYCLES    = 4
) (
  input  logic        clock,
  input  logic        reset_i,
  input  logic [31:0] wr_data_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic        rd_req_i,
  output logic [31:0] rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  input  logic        resync_i,
  output logic        busy_o,
  output logic [7:0]  byte_o,
  input  logic [7:0]  byte_i,
  output logic        ctrl_a_o,
  output logic        ctrl_b_o,
  output logic        ptp_rst_n_o
);

  typedef enum logic [2:0] {
    PRST     = 3'd0,
    IDLE     = 3'd1,
    W_SETUP  = 3'd2,
    W_HOLD   = 3'd3,
    R_SETTLE = 3'd4,
    R_DONE   = 3'd5
  } state_t;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] RST_LD    = 8'(RST_CYCLES - 1);

  state_t      r_state,    w_state;
  logic [7:0]  r_cnt,      w_cnt;
  logic [1:0]  r_widx,     w_widx;
  logic [2:0]  r_ridx,     w_ridx;
  logic [31:0] r_word,     w_word;
  logic [63:0] r_shift,    w_shift;
  logic        r_rs_pend,  w_rs_pend;
  logic        r_rd_pend,  w_rd_pend;
  logic        r_wr_ready, w_wr_ready;
  logic [31:0] r_rd_addr,  w_rd_addr;
  logic [31:0] r_rd_data,  w_rd_data;
  logic        r_rd_valid, w_rd_valid;
  logic        r_busy,     w_busy;
  logic [7:0]  r_byte,     w_byte;
  logic        r_ctrl_a,   w_ctrl_a;
  logic        r_ctrl_b,   w_ctrl_b;
  logic        r_ptp_rst_n, w_ptp_rst_n;
  logic        w_rs_start, w_rd_start;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_widx      = r_widx;
    w_ridx      = r_ridx;
    w_word      = r_word;
    w_shift     = r_shift;
    w_rd_addr   = r_rd_addr;
    w_rd_data   = r_rd_data;
    w_rd_valid  = 1'b0;
    w_byte      = r_byte;
    w_ctrl_a    = r_ctrl_a;
    w_ctrl_b    = r_ctrl_b;
    w_ptp_rst_n = r_ptp_rst_n;
    w_rs_start  = 1'b0;
    w_rd_start  = 1'b0;

    unique case (r_state)
      PRST: begin
        w_ptp_rst_n = 1'b0;
        w_ctrl_a    = 1'b0;
        w_ctrl_b    = 1'b0;
        if (r_cnt == 8'd0) begin
          w_state     = IDLE;
          w_ptp_rst_n = 1'b1;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end

      IDLE: begin
        if (r_rs_pend) begin
          w_rs_start  = 1'b1;
          w_state     = PRST;
          w_cnt       = RST_LD;
          w_ptp_rst_n = 1'b0;
          w_ctrl_a    = 1'b0;
          w_ctrl_b    = 1'b0;
        end else if (wr_valid_i && r_wr_ready) begin
          w_state = W_SETUP;
          w_word  = wr_data_i;
          w_widx  = 2'd0;
          w_byte  = wr_data_i[7:0];
          w_cnt   = SETUP_LD;
        end else if (r_rd_pend) begin
          w_rd_start = 1'b1;
          w_state    = R_SETTLE;
          w_ridx     = 3'd0;
          w_cnt      = SETTLE_LD;
        end
      end

      W_SETUP: begin
        if (r_cnt == 8'd0) begin
          w_ctrl_a = ~r_ctrl_a;
          w_state  = W_HOLD;
          w_cnt    = HOLD_LD;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end

      W_HOLD: begin
        if (r_cnt != 8'd0) begin
          w_cnt = r_cnt - 8'd1;
        end else if (r_widx == 2'd3) begin
          w_state = IDLE;
        end else begin
          // The next byte is only presented on W_SETUP entry, never on a strobe edge.
          w_widx  = r_widx + 2'd1;
          w_byte  = r_word[{w_widx, 3'b000} +: 8];
          w_state = W_SETUP;
          w_cnt   = SETUP_LD;
        end
      end

      R_SETTLE: begin
        if (r_cnt == 8'd0) begin
          w_shift[{r_ridx, 3'b000} +: 8] = byte_i;
          w_ctrl_b = ~r_ctrl_b;
          if (r_ridx == 3'd7) begin
            w_state = R_DONE;
          end else begin
            w_ridx = r_ridx + 3'd1;
            w_cnt  = SETTLE_LD;
          end
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end

      R_DONE: begin
        w_rd_addr  = r_shift[31:0];
        w_rd_data  = r_shift[63:32];
        w_rd_valid = 1'b1;
        w_state    = IDLE;
      end

      default: begin
        w_state     = PRST;
        w_cnt       = RST_LD;
        w_ptp_rst_n = 1'b0;
        w_ctrl_a    = 1'b0;
        w_ctrl_b    = 1'b0;
      end
    endcase

    // A pulse arriving while its flag is already set (or being consumed) is absorbed.
    w_rs_pend  = w_rs_start ? 1'b0 : (r_rs_pend | resync_i);
    w_rd_pend  = w_rd_start ? 1'b0 : (r_rd_pend | rd_req_i);
    w_wr_ready = (w_state == IDLE) && !w_rs_pend;
    w_busy     = (w_state != IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= PRST;
      r_cnt       <= RST_LD;
      r_widx      <= 2'd0;
      r_ridx      <= 3'd0;
      r_word      <= 32'd0;
      r_shift     <= 64'd0;
      r_rs_pend   <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_rd_addr   <= 32'd0;
      r_rd_data   <= 32'd0;
      r_rd_valid  <= 1'b0;
      r_busy      <= 1'b1;
      r_byte      <= 8'h00;
      r_ctrl_a    <= 1'b0;
      r_ctrl_b    <= 1'b0;
      r_ptp_rst_n <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_widx      <= w_widx;
      r_ridx      <= w_ridx;
      r_word      <= w_word;
      r_shift     <= w_shift;
      r_rs_pend   <= w_rs_pend;
      r_rd_pend   <= w_rd_pend;
      r_wr_ready  <= w_wr_ready;
      r_rd_addr   <= w_rd_addr;
      r_rd_data   <= w_rd_data;
      r_rd_valid  <= w_rd_valid;
      r_busy      <= w_busy;
      r_byte      <= w_byte;
      r_ctrl_a    <= w_ctrl_a;
      r_ctrl_b    <= w_ctrl_b;
      r_ptp_rst_n <= w_ptp_rst_n;
    end
  end

  assign wr_ready_o  = r_wr_ready;
  assign rd_addr_o   = r_rd_addr;
  assign rd_data_o   = r_rd_data;
  assign rd_valid_o  = r_rd_valid;
  assign busy_o      = r_busy;
  assign byte_o      = r_byte;
  assign ctrl_a_o    = r_ctrl_a;
  assign ctrl_b_o    = r_ctrl_b;
  assign ptp_rst_n_o = r_ptp_rst_n;

endmodule
